// File: rtl/mpu_bus_master.sv
// rtl/mpu_bus_master.sv - timed MPU bus initiator with setup/strobe/recover phases and read response channel
// Optional address auto-increment pointer enabled by defining MPU_BUS_MASTER_AUTOINC_EN.
module mpu_bus_master #(
    parameter int SETUP_CYCLES   = 1,
    parameter int ACCESS_CYCLES  = 2,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic [1:0]  cmd_be,
    input  logic        cmd_inc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        _mpu_en,
    output logic        _mpu_rd,
    output logic        _mpu_wr,
    output logic [1:0]  _mpu_be,
    output logic [15:0] mpu_addr_out,
    output logic [15:0] mpu_data_out,
    input  logic [15:0] mpu_data_in
);

    generate
        if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
            $error("mpu_bus_master: SETUP_CYCLES must be 1..15");
        end
        if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access
            $error("mpu_bus_master: ACCESS_CYCLES must be 1..15");
        end
        if (RECOVER_CYCLES < 0 || RECOVER_CYCLES > 15) begin : g_bad_recover
            $error("mpu_bus_master: RECOVER_CYCLES must be 0..15");
        end
    endgenerate

    localparam logic [3:0] SETUP_LOAD   = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] ACCESS_LOAD  = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

    state_t      state;
    logic [3:0]  count;
    logic        is_wr;
    logic        accept;
    logic [15:0] next_addr;

    assign cmd_ready = (state == IDLE) & ~rsp_valid & ~reset;
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state != IDLE);

`ifdef MPU_BUS_MASTER_AUTOINC_EN
    logic [15:0] addr_ptr;

    assign next_addr = cmd_inc ? addr_ptr : cmd_addr;

    // Every accepted command leaves the pointer one past the address it used.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_ptr <= 16'h0000;
        end else if (accept) begin
            addr_ptr <= next_addr + 16'd1;
        end
    end
`else
    logic unused_cmd_inc;

    assign unused_cmd_inc = cmd_inc;
    assign next_addr      = cmd_addr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= 4'd0;
            is_wr        <= 1'b0;
            _mpu_en      <= 1'b1;
            _mpu_rd      <= 1'b1;
            _mpu_wr      <= 1'b1;
            _mpu_be      <= 2'b11;
            mpu_addr_out <= 16'h0000;
            mpu_data_out <= 16'h0000;
            rsp_valid    <= 1'b0;
            rsp_data     <= 16'h0000;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        mpu_addr_out <= next_addr;
                        mpu_data_out <= cmd_data;
                        _mpu_be      <= ~cmd_be;
                        is_wr        <= cmd_wr;
                        _mpu_en      <= 1'b0;
                        count        <= SETUP_LOAD;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    if (count == 4'd0) begin
                        count <= ACCESS_LOAD;
                        state <= STROBE;
                        if (is_wr) begin
                            _mpu_wr <= 1'b0;
                        end else begin
                            _mpu_rd <= 1'b0;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                STROBE: begin
                    if (count == 4'd0) begin
                        // Read data is sampled on the same edge that releases the strobe.
                        if (!is_wr) begin
                            rsp_data  <= mpu_data_in;
                            rsp_valid <= 1'b1;
                        end
                        _mpu_en <= 1'b1;
                        _mpu_rd <= 1'b1;
                        _mpu_wr <= 1'b1;
                        _mpu_be <= 2'b11;
                        count   <= RECOVER_LOAD;
                        state   <= (RECOVER_CYCLES == 0) ? IDLE : RECOVER;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RECOVER: begin
                    if (count == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_bus_master.sv
// tb/tb_mpu_bus_master.sv - self-checking bench for mpu_bus_master (default and 3/4/0 timing instances)
module tb_mpu_bus_master;

    localparam int S  = 1;
    localparam int A  = 2;
    localparam int R  = 1;
    localparam int S1 = 3;
    localparam int A1 = 4;

    logic        clk;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_wr, cmd_inc;
    logic [15:0] cmd_addr, cmd_data;
    logic [1:0]  cmd_be;
    logic        rsp_valid, rsp_ready, busy;
    logic [15:0] rsp_data;
    logic        en_n, rd_n, wr_n;
    logic [1:0]  be_n;
    logic [15:0] addr_out, data_out, mpu_data_in;

    logic        cmd_valid1, cmd_ready1, cmd_wr1, cmd_inc1;
    logic [15:0] cmd_addr1, cmd_data1;
    logic [1:0]  cmd_be1;
    logic        rsp_valid1, rsp_ready1, busy1;
    logic [15:0] rsp_data1;
    logic        en_n1, rd_n1, wr_n1;
    logic [1:0]  be_n1;
    logic [15:0] addr_out1, data_out1, mpu_data_in1;

    logic [15:0] rd_value;
    logic [15:0] junk;
    logic [15:0] model_ptr;
    int          checks;
    int          failures;

    // Bus slave: valid data only while the read strobe is active, noise otherwise.
    assign mpu_data_in = (!rd_n && !en_n) ? rd_value : junk;

    mpu_bus_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_be(cmd_be), .cmd_inc(cmd_inc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
        ._mpu_en(en_n), ._mpu_rd(rd_n), ._mpu_wr(wr_n), ._mpu_be(be_n),
        .mpu_addr_out(addr_out), .mpu_data_out(data_out), .mpu_data_in(mpu_data_in)
    );

    mpu_bus_master #(.SETUP_CYCLES(S1), .ACCESS_CYCLES(A1), .RECOVER_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_wr(cmd_wr1),
        .cmd_addr(cmd_addr1), .cmd_data(cmd_data1), .cmd_be(cmd_be1), .cmd_inc(cmd_inc1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .busy(busy1),
        ._mpu_en(en_n1), ._mpu_rd(rd_n1), ._mpu_wr(wr_n1), ._mpu_be(be_n1),
        .mpu_addr_out(addr_out1), .mpu_data_out(data_out1), .mpu_data_in(mpu_data_in1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Cycle k is the clock period following the k-th edge after acceptance (k=1 right after accept).
    task automatic do_cmd0(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                           input logic [1:0] be, input logic [15:0] rdv, input int hold,
                           input logic inc, input logic [15:0] exp_addr);
        int  last;
        logic e_en, e_rd, e_wr, e_busy, e_rv, e_rdy;
        logic [1:0] e_be;
        chk("pre_ready", 16'(cmd_ready), 16'(1'b1));
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_data = data;
        cmd_be = be; cmd_inc = inc; rd_value = rdv;
        tick();
        cmd_valid = 1'b0; cmd_wr = 1'($urandom); cmd_addr = 16'($urandom);
        cmd_data = 16'($urandom); cmd_be = 2'($urandom); cmd_inc = 1'($urandom);
        if (wr) last = S + A + R + 1;
        else last = ((S + A + R) > (S + A + 1 + hold) ? (S + A + R) : (S + A + 1 + hold)) + 1;
        for (int k = 1; k <= last; k++) begin
            rsp_ready = wr ? 1'($urandom) : (k >= S + A + 1 + hold);
            junk      = 16'($urandom);
            e_en   = !(k <= S + A);
            e_rd   = !(!wr && k > S && k <= S + A);
            e_wr   = !(wr && k > S && k <= S + A);
            e_be   = (k <= S + A) ? ~be : 2'b11;
            e_busy = (k <= S + A + R);
            e_rv   = !wr && k >= S + A + 1 && k <= S + A + 1 + hold;
            e_rdy  = (k > S + A + R) && !e_rv;
            chk("mpu_en", 16'(en_n), 16'(e_en));
            chk("mpu_rd", 16'(rd_n), 16'(e_rd));
            chk("mpu_wr", 16'(wr_n), 16'(e_wr));
            chk("mpu_be", 16'(be_n), 16'(e_be));
            chk("addr", addr_out, exp_addr);
            chk("data", data_out, data);
            chk("busy", 16'(busy), 16'(e_busy));
            chk("rsp_valid", 16'(rsp_valid), 16'(e_rv));
            chk("cmd_ready", 16'(cmd_ready), 16'(e_rdy));
            if (e_rv) chk("rsp_data", rsp_data, rdv);
            if (k < last) tick();
        end
    endtask

    task automatic cmd0(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                        input logic [1:0] be, input logic [15:0] rdv, input int hold, input logic inc);
        logic [15:0] ea;
`ifdef MPU_BUS_MASTER_AUTOINC_EN
        ea = inc ? model_ptr : addr;
        model_ptr = ea + 16'd1;
`else
        ea = addr;
`endif
        do_cmd0(wr, addr, data, be, rdv, hold, inc, ea);
    endtask

    initial begin
        logic [15:0] a0, a1, d0, d1, ea;
        int p, j;
        checks = 0; failures = 0; model_ptr = 16'h0000;
        reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 16'h0; cmd_data = 16'h0;
        cmd_be = 2'b00; cmd_inc = 1'b0; rsp_ready = 1'b0; rd_value = 16'h0; junk = 16'h0;
        cmd_valid1 = 1'b0; cmd_wr1 = 1'b0; cmd_addr1 = 16'h0; cmd_data1 = 16'h0;
        cmd_be1 = 2'b00; cmd_inc1 = 1'b0; rsp_ready1 = 1'b1; mpu_data_in1 = 16'h0;
        repeat (3) tick();

        chk("rst_en", 16'(en_n), 16'(1'b1));
        chk("rst_rd", 16'(rd_n), 16'(1'b1));
        chk("rst_wr", 16'(wr_n), 16'(1'b1));
        chk("rst_be", 16'(be_n), 16'(2'b11));
        chk("rst_addr", addr_out, 16'h0000);
        chk("rst_data", data_out, 16'h0000);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'(1'b0));
        chk("rst_rsp_data", rsp_data, 16'h0000);
        chk("rst_busy", 16'(busy), 16'(1'b0));
        chk("rst_cmd_ready", 16'(cmd_ready), 16'(1'b0));
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 16'(cmd_ready), 16'(1'b1));
        chk("post_rst_ready1", 16'(cmd_ready1), 16'(1'b1));

        cmd0(1'b1, 16'h0102, 16'hBEEF, 2'b11, 16'h0, 0, 1'b0);
        cmd0(1'b0, 16'h0040, 16'h5555, 2'b11, 16'h1234, 3, 1'b0);
        cmd0(1'b1, 16'h0300, 16'hA5A5, 2'b10, 16'h0, 0, 1'b0);
        cmd0(1'b0, 16'h0041, 16'h0000, 2'b01, 16'hCAFE, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            cmd0(1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 16'($urandom),
                 int'($urandom_range(0, 4)), 1'($urandom));
        end

        // Reset landing in the middle of a read strobe drops the command.
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0077; cmd_be = 2'b11; rd_value = 16'h7777;
        rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_rd_low", 16'(rd_n), 16'(1'b0));
        reset = 1'b1;
        tick();
        model_ptr = 16'h0000;
        chk("mid_rst_rd", 16'(rd_n), 16'(1'b1));
        chk("mid_rst_en", 16'(en_n), 16'(1'b1));
        chk("mid_rst_rsp_valid", 16'(rsp_valid), 16'(1'b0));
        chk("mid_rst_busy", 16'(busy), 16'(1'b0));
        chk("mid_rst_ready", 16'(cmd_ready), 16'(1'b0));
        reset = 1'b0;
        tick();
        chk("mid_rst_after_ready", 16'(cmd_ready), 16'(1'b1));
        chk("mid_rst_after_rsp", 16'(rsp_valid), 16'(1'b0));

`ifdef MPU_BUS_MASTER_AUTOINC_EN
        do_cmd0(1'b1, 16'hFFFE, 16'h1111, 2'b11, 16'h0, 0, 1'b0, 16'hFFFE);
        do_cmd0(1'b1, 16'h1234, 16'h2222, 2'b11, 16'h0, 0, 1'b1, 16'hFFFF);
        do_cmd0(1'b1, 16'h4321, 16'h3333, 2'b11, 16'h0, 0, 1'b1, 16'h0000);
        model_ptr = 16'h0001;
`endif

        // Back-to-back writes on the 3/4/0 instance with cmd_valid held throughout.
        a0 = 16'($urandom); d0 = 16'($urandom);
        a1 = 16'($urandom); d1 = 16'($urandom);
        cmd_valid1 = 1'b1; cmd_wr1 = 1'b1; cmd_addr1 = a0; cmd_data1 = d0; cmd_be1 = 2'b11;
        chk("b2b_pre_ready", 16'(cmd_ready1), 16'(1'b1));
        tick();
        cmd_addr1 = a1; cmd_data1 = d1; cmd_be1 = 2'b01;
        for (int k = 1; k <= 16; k++) begin
            j = (k - 1) / 8;
            p = (k - 1) % 8 + 1;
            ea = (j == 0) ? a0 : a1;
            chk("b2b_en", 16'(en_n1), 16'(!(p <= S1 + A1)));
            chk("b2b_wr", 16'(wr_n1), 16'(!(p > S1 && p <= S1 + A1)));
            chk("b2b_rd", 16'(rd_n1), 16'(1'b1));
            chk("b2b_addr", addr_out1, ea);
            chk("b2b_data", data_out1, (j == 0) ? d0 : d1);
            chk("b2b_be", 16'(be_n1), 16'((p <= S1 + A1) ? ((j == 0) ? 2'b00 : 2'b10) : 2'b11));
            chk("b2b_ready", 16'(cmd_ready1), 16'(p == 8));
            chk("b2b_rsp_valid", 16'(rsp_valid1), 16'(1'b0));
            if (k == 9) cmd_valid1 = 1'b0;
            if (k < 16) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
